// File: rtl/sram1rw_req_adapter.sv
// Request front end for a single-port SRAM1RW1024x38 macro: post-reset scrub,
// valid/ready request conversion to active-low strobes, and a credit-managed read response FIFO.
module sram1rw_req_adapter #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 38,
   parameter int DEPTH     = 1024,
   parameter int RSP_DEPTH = 3,
   parameter int INIT_EN   = 1,
   parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DATA_W-1:0] o_rsp_rdata,
   output logic              o_init_done,
   output logic [ADDR_W-1:0] o_mem_a,
   output logic [DATA_W-1:0] o_mem_i,
   output logic              o_mem_csb,
   output logic              o_mem_web,
   output logic              o_mem_oeb,
   input  logic [DATA_W-1:0] i_mem_o
);

   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);
   localparam logic [CNT_W:0]    CREDITS  = RSP_DEPTH[CNT_W:0];
   localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(RSP_DEPTH - 1);
   localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic {S_INIT, S_RUN} state_t;
   localparam state_t RST_STATE = (INIT_EN != 0) ? S_INIT : S_RUN;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_cnt;
   logic                r_init_done;
   logic                r_rd_pend;
   logic [ADDR_W-1:0]   r_a_hold;
   logic [DATA_W-1:0]   r_i_hold;
   logic [DATA_W-1:0]   r_fifo [RSP_DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic [CNT_W:0]      w_used;
   logic                w_ready;
   logic                w_fire;
   logic                w_push;
   logic                w_pop;

   // Credits cover both stored responses and the read whose data is still on mem_o.
   assign w_used  = {1'b0, r_count} + {{CNT_W{1'b0}}, r_rd_pend};
   assign w_ready = !i_reset && (r_state == S_RUN) && (w_used < CREDITS);
   assign w_fire  = i_req_valid && w_ready;
   assign w_push  = r_rd_pend;
   assign w_pop   = i_rsp_ready && (r_count != '0);

   assign o_req_ready = w_ready;
   assign o_rsp_valid = (r_count != '0);
   assign o_rsp_rdata = r_fifo[r_rd_ptr];
   assign o_init_done = r_init_done;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) r_state <= RST_STATE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      o_mem_csb   = 1'b1;
      o_mem_web   = 1'b1;
      o_mem_oeb   = 1'b1;
      o_mem_a     = r_a_hold;
      o_mem_i     = r_i_hold;
      if (!i_reset) begin
         case (r_state)
            S_INIT: begin
               o_mem_csb = 1'b0;
               o_mem_web = 1'b0;
               o_mem_a   = r_cnt;
               o_mem_i   = INIT_VALUE;
               if (r_cnt == CNT_LAST) w_state_nxt = S_RUN;
            end
            S_RUN: begin
               if (w_fire) begin
                  o_mem_csb = 1'b0;
                  o_mem_a   = i_req_addr;
                  if (i_req_we) begin
                     o_mem_web = 1'b0;
                     o_mem_i   = i_req_wdata;
                  end else begin
                     o_mem_oeb = 1'b0;
                  end
               end
            end
            default: w_state_nxt = RST_STATE;
         endcase
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_cnt       <= '0;
         r_init_done <= 1'b0;
         r_rd_pend   <= 1'b0;
         r_a_hold    <= '0;
         r_i_hold    <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
      end else begin
         if (r_state == S_INIT) r_cnt <= r_cnt + ADDR_W'(1);
         r_init_done <= r_init_done | (r_state == S_RUN);
         r_rd_pend   <= w_fire && !i_req_we;
         if (!o_mem_csb) r_a_hold <= o_mem_a;
         if (!o_mem_csb && !o_mem_web) r_i_hold <= o_mem_i;
         if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Macro output is valid for exactly the cycle after the read strobe.
   always_ff @(posedge i_clock) begin
      if (w_push) r_fifo[r_wr_ptr] <= i_mem_o;
   end

   a_credit: assert property (@(posedge i_clock) disable iff (i_reset) w_used <= CREDITS);

endmodule
